// File: rtl/mac_pkg.sv
// Shared widths, FSM state type and result helpers for the MAC sequencer.
// Build option: MAC_SAT_EN selects saturating results instead of wrapping.
package mac_pkg;

    localparam int INT_BITS  = 7;
    localparam int FRAC_BITS = 9;
    localparam int LEN_W     = 8;
    localparam int GUARD     = 8;
    localparam int W         = INT_BITS + FRAC_BITS;
    localparam int PW        = 2 * W;
    localparam int ACC_W     = PW + GUARD;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    // Overflow when the guard bits plus result MSB are not all equal
    function automatic logic acc_ovf(
        input logic [ACC_W-1:0] acc
    );
        return !((&acc[ACC_W-1:PW-1]) || (~|acc[ACC_W-1:PW-1]));
    endfunction

    function automatic logic [PW-1:0] sat_trunc(
        input logic [ACC_W-1:0] acc
    );
`ifdef MAC_SAT_EN
        if (acc_ovf(acc))
            return acc[ACC_W-1] ? {1'b1, {(PW-1){1'b0}}}
                                : {1'b0, {(PW-1){1'b1}}};
        return acc[PW-1:0];
`else
        return acc[PW-1:0];
`endif
    endfunction

endpackage

// File: rtl/mac_pe.sv
// Signed multiply-add processing element.
// Build option: none.
module mac_pe
    import mac_pkg::*;
(
    input  logic signed [W-1:0]  i_a,
    input  logic signed [W-1:0]  i_b,
    input  logic signed [PW-1:0] i_data_adder,
    output logic signed [PW-1:0] o_prod
);

    assign o_prod = i_a * i_b + i_data_adder;

endmodule

// File: rtl/mac_seq_ctrl.sv
// Sequences one mac_pe through a LEN-pair signed dot product.
// Build option: MAC_SAT_EN clamps overflowing results.
module mac_seq_ctrl
    import mac_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [PW-1:0]    res_data,
    output logic             res_ovf
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [LEN_W-1:0]   r_cnt;
    logic [PW-1:0]      r_p_q;
    logic               r_pv;
    logic [ACC_W-1:0]   r_acc;
    logic [PW-1:0]      r_res_data;
    logic               r_res_ovf;

    logic               w_hs;
    logic               w_last;
    logic [PW-1:0]      w_prod;
    logic [ACC_W-1:0]   w_p_ext;
    logic [ACC_W-1:0]   w_acc_nxt;

    mac_pe u_pe (
        .i_a          (in_a),
        .i_b          (in_b),
        .i_data_adder ({PW{1'b0}}),
        .o_prod       (w_prod)
    );

    assign w_hs      = in_valid && in_ready;
    assign w_last    = w_hs && (r_cnt == LEN_W'(1));
    assign w_p_ext   = {{GUARD{r_p_q[PW-1]}}, r_p_q};
    // Product captured last edge is folded in one cycle later
    assign w_acc_nxt = r_pv ? (r_acc + w_p_ext) : r_acc;
    assign res_data  = r_res_data;
    assign res_ovf   = r_res_ovf;

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b1;
        in_ready    = 1'b0;
        res_valid   = 1'b0;
        unique case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start)
                    w_state_nxt = (len == '0) ? DONE : RUN;
            end
            RUN: begin
                in_ready = 1'b1;
                if (w_last)
                    w_state_nxt = DRAIN;
            end
            DRAIN: w_state_nxt = DONE;
            DONE: begin
                res_valid = 1'b1;
                if (res_ready)
                    w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_p_q      <= '0;
            r_pv       <= 1'b0;
            r_acc      <= '0;
            r_res_data <= '0;
            r_res_ovf  <= 1'b0;
        end else begin
            r_pv <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_cnt <= len;
                        r_acc <= '0;
                        if (len == '0) begin
                            r_res_data <= '0;
                            r_res_ovf  <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    r_acc <= w_acc_nxt;
                    if (w_hs) begin
                        r_p_q <= w_prod;
                        r_pv  <= 1'b1;
                        r_cnt <= r_cnt - LEN_W'(1);
                    end
                end
                DRAIN: begin
                    r_acc      <= w_acc_nxt;
                    r_res_data <= sat_trunc(w_acc_nxt);
                    r_res_ovf  <= acc_ovf(w_acc_nxt);
                end
                DONE: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Scoreboard bench for mac_seq_ctrl.
// Build option: MAC_SAT_EN changes the expected wrap/clamp result.
module tb_mac_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  len = '0;
    logic        busy;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_data;
    logic        res_ovf;

    int vectors = 0;
    int miscompares = 0;

    logic [32:0] sb_q[$];
    logic [15:0] va[$];
    logic [15:0] vb[$];

    mac_seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_ovf   (res_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pairs(input int n, input logic [15:0] a,
                             input logic [15:0] b);
        va.delete();
        vb.delete();
        for (int i = 0; i < n; i++) begin
            va.push_back(a);
            vb.push_back(b);
        end
    endtask

    task automatic push_expect(input int n);
        longint acc;
        logic   ovf;
        logic [31:0] d;
        acc = 0;
        for (int i = 0; i < n; i++)
            acc += longint'($signed(va[i])) * longint'($signed(vb[i]));
        ovf = (acc > 64'sd2147483647) || (acc < -64'sd2147483648);
        d = acc[31:0];
`ifdef MAC_SAT_EN
        if (ovf)
            d = (acc < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        sb_q.push_back({ovf, d});
    endtask

    task automatic drive_job(input string tag, input int n, input bit gaps);
        int i;
        int cyc;
        bit hs;
        push_expect(n);
        start = 1'b1;
        len   = 8'(n);
        tick();
        start = 1'b0;
        if (n == 0) begin
            chk({tag, "_done"}, 64'(res_valid), 64'd1);
            chk({tag, "_rdy"}, 64'(in_ready), 64'd0);
            return;
        end
        i = 0;
        cyc = 0;
        while (i < n && cyc < 4000) begin
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_a = va[i];
            in_b = vb[i];
            hs = in_valid && in_ready;
            tick();
            if (hs) i++;
            cyc++;
        end
        in_valid = 1'b0;
        chk({tag, "_pairs"}, 64'(i), 64'(n));
        chk({tag, "_drain"}, 64'(res_valid), 64'd0);
        tick();
        chk({tag, "_lat"}, 64'(res_valid), 64'd1);
    endtask

    task automatic collect(input string tag);
        logic [32:0] e;
        int cyc;
        cyc = 0;
        while (!res_valid && cyc < 100) begin
            tick();
            cyc++;
        end
        chk({tag, "_vld"}, 64'(res_valid), 64'd1);
        if (sb_q.size() == 0) begin
            chk({tag, "_sb"}, 64'd0, 64'd1);
            return;
        end
        e = sb_q.pop_front();
        chk({tag, "_data"}, 64'(res_data), 64'(e[31:0]));
        chk({tag, "_ovf"}, 64'(res_ovf), 64'(e[32]));
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_rdy"}, 64'(in_ready), 64'd0);
        chk({tag, "_vld"}, 64'(res_valid), 64'd0);
        chk({tag, "_data"}, 64'(res_data), 64'd0);
        chk({tag, "_ovf"}, 64'(res_ovf), 64'd0);
    endtask

    initial begin
        logic [31:0] held;
        rst = 1'b1;
        tick();
        tick();
        chk_zero("rst");
        rst = 1'b0;
        tick();

        set_pairs(4, 16'h0200, 16'h0400);
        drive_job("t1", 4, 1'b0);
        collect("t1");

        drive_job("t2", 0, 1'b0);
        collect("t2");

        va.delete();
        vb.delete();
        va.push_back(16'h0300); vb.push_back(16'hFC00);
        va.push_back(16'h0100); vb.push_back(16'h0100);
        drive_job("t3", 2, 1'b1);
        collect("t3");

        set_pairs(255, 16'h8000, 16'h8000);
        drive_job("t4", 255, 1'b0);
        collect("t4");

        set_pairs(3, 16'h0180, 16'hFE00);
        drive_job("t5", 3, 1'b1);
        held = res_data;
        for (int k = 0; k < 5; k++) begin
            start = (k == 2);
            len   = 8'd3;
            tick();
            chk("t5_hold", 64'(res_data), 64'(held));
            chk("t5_rdy", 64'(in_ready), 64'd0);
            chk("t5_vld", 64'(res_valid), 64'd1);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        collect("t5");

        set_pairs(4, 16'h0200, 16'h0400);
        start = 1'b1;
        len   = 8'd4;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        in_a = 16'h0200;
        in_b = 16'h0400;
        tick();
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_zero("t6");
        set_pairs(1, 16'h0200, 16'h0200);
        drive_job("t6j", 1, 1'b0);
        collect("t6j");

        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
